dmem_axi_bridge: RTL and testbench

- Memory-side responder for the CPU data port. The datapath issues SRAM-like requests (enable, byte write-enable, address, write data) and expects read data plus a stall signal back.
- This block accepts one request at a time and converts it into a single-beat AXI4 read or write transaction.
- It holds data_stall high until the transaction completes, then returns read data.
- It sits between the datapath's M stage and the system AXI interconnect.

---
 rtl/cpu_axi_pkg.sv | 33 +++
 rtl/dmem_axi_bridge_if.sv | 69 ++++++
 rtl/axi_wr_chan_tracker.sv | 46 ++++
 rtl/dmem_axi_bridge.sv | 157 +++++++++++++++
 tb/tb_dmem_axi_bridge.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU data-port to AXI4 bridge.
// Contents: bridge FSM state encoding, AXI size/burst constants and the
// byte-enable to AXI transfer-size mapping used on the write address channel.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } bridgeState_t;

  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Narrowest AXI size covering the enabled lanes; irregular masks fall back
  // to a full word and rely on wstrb to select the bytes.
  function automatic logic [2:0] wen_to_size(input logic [3:0] wen);
    logic [2:0] size;
    case (wen)
      4'b1111:                            size = SIZE_W;
      4'b0011, 4'b1100:                   size = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
      default:                            size = SIZE_W;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_axi_bridge_if.sv
// AXI4 single-beat bus between the data-memory bridge and the interconnect.
// Channels: AR/R (read), AW/W/B (write).
// modport master: the bridge side (drives valids on AR/AW/W, readies on R/B).
// modport slave : the interconnect side.
interface dmem_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata_axi;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_chan_tracker.sv
// Tracks the independent AW and W handshakes of one single-beat write.
// Ports:
//   clk, rst        core clock, asynchronous active-low reset
//   active          bridge is in its write-issue state
//   awready, wready slave readies
//   awvalid, wvalid channel valids (each drops after its own handshake)
//   bothDone        one-cycle pulse when both channels have completed,
//                   including when the last two handshakes share a cycle
module axi_wr_chan_tracker (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic bothDone
);

  logic awDone;
  logic wDone;

  assign awvalid  = active & ~awDone;
  assign wvalid   = active & ~wDone;
  // A channel counts as finished if it already handshook or does so now.
  assign bothDone = active & (awDone | awready) & (wDone | wready);

  // Per-channel completion flags, cleared once the pair is complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awDone <= 1'b0;
      wDone  <= 1'b0;
    end else if (bothDone) begin
      awDone <= 1'b0;
      wDone  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awDone <= 1'b1;
      end
      if (wvalid && wready) begin
        wDone <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_axi_bridge.sv
// CPU data-port responder: turns one SRAM-style request into one single-beat
// AXI4 read or write and stalls the CPU until it completes.
// Ports:
//   clk, rst     core clock, asynchronous active-low reset
//   req_en       request valid, sampled only in IDLE
//   req_wen      byte write enables (0 = load)
//   req_addr     byte address
//   req_wdata    lane-aligned store data
//   rdata        load data, valid in DONE and held until the next load
//   data_stall   pipeline hold, req_en & (state != DONE)
//   axi          AXI4 master port
module dmem_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic [3:0]        req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              data_stall,
  dmem_axi_bridge_if.master axi
);

  bridgeState_t      state;
  bridgeState_t      nextState;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [3:0]        wenQ;
  logic              wrActive;
  logic              bothDone;
  logic              unusedRespBits;

  // Response IDs and status are not acted on by this bridge.
  assign unusedRespBits = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req_en) begin
          if (req_wen == 4'b0000) begin
            nextState = RD_ADDR;
          end else begin
            nextState = WR;
          end
        end else begin
          nextState = IDLE;
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          nextState = RD_DATA;
        end else begin
          nextState = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          nextState = DONE;
        end else begin
          nextState = RD_DATA;
        end
      end
      WR: begin
        if (bothDone) begin
          nextState = WR_RESP;
        end else begin
          nextState = WR;
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          nextState = DONE;
        end else begin
          nextState = WR_RESP;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture; the bus is driven from these copies so the CPU may
  // change its inputs while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ  <= '0;
      wdataQ <= '0;
      wenQ   <= 4'b0000;
    end else if ((state == IDLE) && req_en) begin
      addrQ  <= req_addr;
      wdataQ <= req_wdata;
      wenQ   <= req_wen;
    end
  end

  // Load data capture, held until the next load completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if ((state == RD_DATA) && axi.rvalid) begin
      rdata <= axi.rdata_axi;
    end
  end

  assign data_stall = req_en & (state != DONE);

  // Read address / data channels
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = {addrQ[ADDR_W-1:2], 2'b00};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = SIZE_W;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = (state == RD_ADDR);
  assign axi.rready  = (state == RD_DATA);

  // Write address / data / response channels
  assign wrActive    = (state == WR);
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addrQ;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = wen_to_size(wenQ);
  assign axi.awburst = BURST_INCR;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdataQ;
  assign axi.wstrb   = wenQ;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = (state == WR_RESP);

  axi_wr_chan_tracker uWrTracker (
    .clk      (clk),
    .rst      (rst),
    .active   (wrActive),
    .awready  (axi.awready),
    .wready   (axi.wready),
    .awvalid  (axi.awvalid),
    .wvalid   (axi.wvalid),
    .bothDone (bothDone)
  );

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Self-checking bench for dmem_axi_bridge: directed test-plan cases plus
// randomized loads/stores against a transaction-level reference model.
module tb_dmem_axi_bridge;
  import cpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_en;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        data_stall;

  int errCount   = 0;
  int checkCount = 0;
  logic [31:0] modelRdata = 32'd0;

  always #5 clk = ~clk;

  dmem_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  dmem_axi_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_en     (req_en),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .data_stall (data_stall),
    .axi        (axi)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference size rule: one lane -> byte, aligned half -> half, else word.
  function automatic logic [2:0] expSize(input logic [3:0] wen);
    if ($countones(wen) == 1) return 3'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  task automatic clearSlave();
    axi.arready   = 1'b0;
    axi.rvalid    = 1'b0;
    axi.rdata_axi = 32'd0;
    axi.rid       = 4'd0;
    axi.rresp     = 2'd0;
    axi.rlast     = 1'b0;
    axi.awready   = 1'b0;
    axi.wready    = 1'b0;
    axi.bvalid    = 1'b0;
    axi.bid       = 4'd0;
    axi.bresp     = 2'd0;
  endtask

  // One request from IDLE to DONE. Called and returns at a negedge.
  // Read: d1 = cycles arvalid waits for arready, d2 = cycles rready waits for rvalid.
  // Write: d1 = AW wait, d2 = W wait, d3 = B wait.
  task automatic doTxn(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wen, input logic [31:0] rval,
                       input int d1, input int d2, input int d3, input bit midChange);
    int stallCnt = 0, arHs = 0, rHs = 0, awHs = 0, wHs = 0, bHs = 0, bRise = 0, viol = 0;
    int arvCnt = 0, rrCnt = 0, awvCnt = 0, wvCnt = 0, brCnt = 0, cyc = 0, expStall;
    bit pendAr = 0, pendAw = 0, pendW = 0, prevBr = 0, done = 0;
    logic [31:0] lastAraddr = 32'd0, lastAwaddr = 32'd0, lastWdata = 32'd0;
    logic [2:0]  lastAwsize = 3'd0;
    logic [3:0]  lastWstrb = 4'd0;
    req_en    = 1'b1;
    req_wen   = isWrite ? wen : 4'b0000;
    req_addr  = addr;
    req_wdata = wdata;
    while (!done && cyc < 200) begin
      #1;
      clearSlave();
      if (!data_stall) begin
        done = 1;
        if (!isWrite) checkVal("rdataDone", rdata, rval);
        checkVal("doneValids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'd0);
      end else begin
        stallCnt++;
        if (axi.arvalid) begin
          arvCnt++;
          if (arvCnt == 1) begin
            checkVal("araddr", axi.araddr, addr & 32'hFFFF_FFFC);
            checkVal("arsize", axi.arsize, 3'd2);
            checkVal("arFixed", {axi.arlen, axi.arburst, axi.arid}, {8'd0, 2'b01, 4'd1});
            lastAraddr = axi.araddr;
          end else if (axi.araddr !== lastAraddr) viol++;
          if (arvCnt > d1) begin axi.arready = 1'b1; arHs++; end
        end else if (pendAr) viol++;
        pendAr = axi.arvalid && !axi.arready;
        if (axi.rready) begin
          rrCnt++;
          axi.rresp = 2'($urandom);
          if (rrCnt > d2) begin
            axi.rvalid = 1'b1; axi.rdata_axi = rval; axi.rlast = 1'b1; rHs++;
          end else axi.rdata_axi = $urandom;
        end
        if (axi.awvalid) begin
          awvCnt++;
          if (awvCnt == 1) begin
            checkVal("awaddr", axi.awaddr, addr);
            checkVal("awsize", axi.awsize, expSize(wen));
            checkVal("awFixed", {axi.awlen, axi.awburst, axi.awid}, {8'd0, 2'b01, 4'd1});
            lastAwaddr = axi.awaddr; lastAwsize = axi.awsize;
          end else if (axi.awaddr !== lastAwaddr || axi.awsize !== lastAwsize) viol++;
          if (awvCnt > d1) begin axi.awready = 1'b1; awHs++; end
        end else if (pendAw) viol++;
        pendAw = axi.awvalid && !axi.awready;
        if (axi.wvalid) begin
          wvCnt++;
          if (wvCnt == 1) begin
            checkVal("wdata", axi.wdata, wdata);
            checkVal("wstrb", axi.wstrb, wen);
            checkVal("wlastId", {axi.wlast, axi.wid}, {1'b1, 4'd1});
            lastWdata = axi.wdata; lastWstrb = axi.wstrb;
          end else if (axi.wdata !== lastWdata || axi.wstrb !== lastWstrb) viol++;
          if (wvCnt > d2) begin axi.wready = 1'b1; wHs++; end
        end else if (pendW) viol++;
        pendW = axi.wvalid && !axi.wready;
        if (axi.bready) begin
          brCnt++;
          if (!prevBr) bRise++;
          axi.bresp = 2'($urandom);
          if (brCnt > d3) begin axi.bvalid = 1'b1; bHs++; end
        end
        prevBr = axi.bready;
        if (midChange && cyc > 0) begin
          req_addr  = $urandom;
          req_wdata = $urandom;
          req_wen   = 4'($urandom);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) checkVal("timeout", 64'd0, 64'd1);
    expStall = isWrite ? (3 + ((d1 > d2) ? d1 : d2) + d3) : (3 + d1 + d2);
    checkVal("stallCycles", stallCnt, expStall);
    checkVal("stableHeld", viol, 0);
    if (isWrite) begin
      checkVal("hsCounts", {8'(arHs), 8'(rHs), 8'(awHs), 8'(wHs), 8'(bHs)}, {8'd0, 8'd0, 8'd1, 8'd1, 8'd1});
      checkVal("wrRespEntries", bRise, 1);
    end else begin
      modelRdata = rval;
      checkVal("hsCounts", {8'(arHs), 8'(rHs), 8'(awHs), 8'(wHs), 8'(bHs)}, {8'd1, 8'd1, 8'd0, 8'd0, 8'd0});
    end
  endtask

  // One cycle with no request: no stall, bus quiet, load data held.
  task automatic idleGap();
    req_en = 1'b0;
    #1;
    checkVal("idleStall", data_stall, 1'b0);
    checkVal("idleValids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'd0);
    checkVal("rdataHeld", rdata, modelRdata);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] wenTab [8];
    wenTab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    req_en = 1'b0; req_wen = 4'b0000; req_addr = 32'd0; req_wdata = 32'd0;
    clearSlave();
    @(negedge clk); @(negedge clk);
    #1;
    checkVal("rstValids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'd0);
    checkVal("rstStall", data_stall, 1'b0);
    checkVal("rstRdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Word load, zero-wait
    doTxn(1'b0, 32'h8000_0104, 32'd0, 4'b0000, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    idleGap();
    // Byte store, zero-wait
    doTxn(1'b1, 32'h8000_0203, 32'hAB00_0000, 4'b1000, 32'd0, 0, 0, 0, 1'b0);
    idleGap();
    // Store with W completing 4 cycles ahead of AW
    doTxn(1'b1, 32'h8000_0300, 32'h1234_5678, 4'b1111, 32'd0, 4, 0, 1, 1'b0);
    idleGap();
    // Store with AW/W handshakes in the same cycle
    doTxn(1'b1, 32'h8000_0310, 32'hCAFE_F00D, 4'b1111, 32'd0, 2, 2, 0, 1'b0);
    idleGap();
    // Backpressured load with CPU inputs wandering while stalled
    doTxn(1'b0, 32'h8000_0404, 32'd0, 4'b0000, 32'h0BAD_F00D, 5, 3, 0, 1'b1);
    idleGap();
    // Back-to-back load then store, req_en held across the DONE edge
    doTxn(1'b0, 32'h8000_0500, 32'd0, 4'b0000, 32'h5555_AAAA, 0, 1, 0, 1'b0);
    doTxn(1'b1, 32'h8000_0504, 32'h0000_00EE, 4'b0001, 32'd0, 1, 0, 0, 1'b0);
    idleGap();

    // Reset while waiting in the read-data phase
    req_en = 1'b1; req_wen = 4'b0000; req_addr = 32'h8000_0600;
    for (int c = 0; c < 20; c++) begin
      #1;
      clearSlave();
      if (axi.rready) break;
      if (axi.arvalid) axi.arready = 1'b1;
      @(negedge clk);
    end
    checkVal("reachedRdData", axi.rready, 1'b1);
    rst = 1'b0;
    req_en = 1'b0;
    #1;
    checkVal("midRstBus", {axi.arvalid, axi.rready, data_stall}, 3'd0);
    checkVal("midRstRdata", rdata, 32'd0);
    modelRdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    doTxn(1'b0, 32'h8000_0700, 32'd0, 4'b0000, 32'h7777_0001, 0, 0, 0, 1'b0);
    idleGap();

    // Randomized loads and stores
    for (int i = 0; i < 25; i++) begin
      bit          isW;
      logic [3:0]  wen;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rv;
      isW = 1'($urandom_range(0, 1));
      wen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : wenTab[$urandom_range(0, 7)];
      a   = $urandom;
      d   = $urandom;
      rv  = $urandom;
      doTxn(isW, a, d, wen, rv, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idleGap();
    end
    idleGap();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
